// File: rtl/pipelined_adder_if.sv
// Streaming operand/result bundle for the pipelined adder/subtractor.
// The producer/consumer side uses master; the adder uses slave.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: one SW-bit slice per stage, carry registered
// between stages, valid/ready handshake with a single global stall.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic clk,
    input logic rst_n,
    pipelined_adder_if.slave bus
);
    localparam int SW = WIDTH / STAGES;

    logic             stall;
    logic             adv;
    logic             take;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign adv          = ~stall;
    assign bus.in_ready = adv;
    assign take         = bus.in_valid & adv;

    // Subtraction is A + ~B + 1, so cin is overridden when sub is set.
    assign b_eff = bus.sub ? ~bus.b : bus.b;
    assign c0    = bus.sub | bus.cin;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            localparam int DONE = (k + 1) * SW;

            logic [SW-1:0]   a_sl;
            logic [SW-1:0]   b_sl;
            logic            c_in;
            logic            v_in;
            logic [SW:0]     add;
            logic [DONE-1:0] sum_d;
            logic            v_q;
            logic            c_q;
            logic [DONE-1:0] sum_q;

            if (k == 0) begin : g_src
                assign a_sl  = bus.a[SW-1:0];
                assign b_sl  = b_eff[SW-1:0];
                assign c_in  = c0;
                assign v_in  = take;
                assign sum_d = add[SW-1:0];
            end else begin : g_src
                assign a_sl  = g_stage[k-1].g_ops.a_q[SW-1:0];
                assign b_sl  = g_stage[k-1].g_ops.b_q[SW-1:0];
                assign c_in  = g_stage[k-1].c_q;
                assign v_in  = g_stage[k-1].v_q;
                assign sum_d = {add[SW-1:0], g_stage[k-1].sum_q};
            end

            assign add = {1'b0, a_sl} + {1'b0, b_sl} + {{SW{1'b0}}, c_in};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q   <= 1'b0;
                    c_q   <= 1'b0;
                    sum_q <= '0;
                end else if (adv) begin
                    v_q   <= v_in;
                    c_q   <= add[SW];
                    sum_q <= sum_d;
                end
            end

            // Operand slices not yet consumed travel alongside the partial sum.
            if (k < STAGES - 1) begin : g_ops
                localparam int REM = WIDTH - DONE;

                logic [REM-1:0] a_d;
                logic [REM-1:0] b_d;
                logic [REM-1:0] a_q;
                logic [REM-1:0] b_q;

                if (k == 0) begin : g_in
                    assign a_d = bus.a[WIDTH-1:SW];
                    assign b_d = b_eff[WIDTH-1:SW];
                end else begin : g_in
                    assign a_d = g_stage[k-1].g_ops.a_q[WIDTH-k*SW-1:SW];
                    assign b_d = g_stage[k-1].g_ops.b_q[WIDTH-k*SW-1:SW];
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else if (adv) begin
                        a_q <= a_d;
                        b_q <= b_d;
                    end
                end
            end

            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            if (k == STAGES - 1) begin : g_ovf
                logic ovf_q;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ovf_q <= 1'b0;
                    end else if (adv) begin
                        ovf_q <= add[SW] ^ (a_sl[SW-1] ^ b_sl[SW-1] ^ add[SW-1]);
                    end
                end
            end
        end
    endgenerate

    assign bus.out_valid = g_stage[STAGES-1].v_q;
    assign bus.sum       = g_stage[STAGES-1].sum_q;
    assign bus.cout      = g_stage[STAGES-1].c_q;
    assign bus.ovf       = g_stage[STAGES-1].g_ovf.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: expected results are queued at acceptance
// from an integer-arithmetic model and popped by an independent output monitor.
module tb_pipelined_adder;
    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    int   n_stall  = 0;

    // Reference: plain unsigned/signed integer arithmetic on the whole word.
    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        longint ua, ub, sa, sb, u, s, smax, smin;
        res_t   r;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        smax = (longint'(1) <<< (WIDTH - 1)) - 1;
        smin = -(longint'(1) <<< (WIDTH - 1));
        if (sub) begin
            u      = ua - ub;
            s      = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            u      = ua + ub + longint'(cin);
            s      = sa + sb + longint'(cin);
            r.cout = (u >= (longint'(1) <<< WIDTH));
        end
        r.sum = u[WIDTH-1:0];
        r.ovf = (s > smax) || (s < smin);
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
    endtask

    // Acceptance recorder: a transfer is committed on the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
        end
    end

    // Output monitor.
    initial begin
        logic prev_stall;
        res_t snap;
        logic snap_v;
        res_t r;
        prev_stall = 1'b0;
        snap       = '0;
        snap_v     = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                chk("in_ready_vs_stall", longint'(bus.in_ready),
                    longint'(!(bus.out_valid && !bus.out_ready)));
                if (prev_stall) begin
                    chk("stall_hold_valid", longint'(bus.out_valid), longint'(snap_v));
                    chk("stall_hold_sum", longint'(bus.sum), longint'(snap.sum));
                    chk("stall_hold_cout", longint'(bus.cout), longint'(snap.cout));
                    chk("stall_hold_ovf", longint'(bus.ovf), longint'(snap.ovf));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: got sum 0x%0h, expected no result (t=%0t)",
                                 bus.sum, $time);
                    end else begin
                        r = exp_q.pop_front();
                        n_out++;
                        chk("sb_sum", longint'(bus.sum), longint'(r.sum));
                        chk("sb_cout", longint'(bus.cout), longint'(r.cout));
                        chk("sb_ovf", longint'(bus.ovf), longint'(r.ovf));
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                if (prev_stall) begin
                    n_stall++;
                    snap_v    = bus.out_valid;
                    snap.sum  = bus.sum;
                    snap.cout = bus.cout;
                    snap.ovf  = bus.ovf;
                end
            end
        end
    end

    // One operation through an empty pipe with out_ready=1: checks exact latency and value.
    task automatic single_op(input string name, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic cin, input logic sub,
                             input logic [WIDTH-1:0] e_sum, input logic e_cout,
                             input logic e_ovf);
        int g;
        @(posedge clk);
        #1 drive(a, b, cin, sub);
        g = 0;
        @(negedge clk);
        while (!bus.in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk({name, "_accept_timeout"}, longint'(g < 20), 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int i = 1; i <= STAGES; i++) begin
            @(negedge clk);
            chk($sformatf("%s_valid_c%0d", name, i), longint'(bus.out_valid),
                longint'(i == STAGES));
        end
        chk({name, "_sum"}, longint'(bus.sum), longint'(e_sum));
        chk({name, "_cout"}, longint'(bus.cout), longint'(e_cout));
        chk({name, "_ovf"}, longint'(bus.ovf), longint'(e_ovf));
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 60) begin
            @(negedge clk);
            g++;
        end
        #1;
        chk({name, "_drain"}, longint'(exp_q.size()), 0);
    endtask

    initial begin
        int n0;
        int s0;
        int g;
        logic [2:0] bits;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        #12;
        chk("reset_out_valid", longint'(bus.out_valid), 0);
        chk("reset_sum", longint'(bus.sum), 0);
        chk("reset_cout", longint'(bus.cout), 0);
        chk("reset_ovf", longint'(bus.ovf), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("reset_in_ready", longint'(bus.in_ready), 1);

        // All eight LSB combinations of (a[0], b[0], cin).
        for (int i = 0; i < 8; i++) begin
            bits = 3'(i);
            single_op($sformatf("lsb%0d", i), WIDTH'(bits[2]), WIDTH'(bits[1]), bits[0], 1'b0,
                      WIDTH'(bits[2]) + WIDTH'(bits[1]) + WIDTH'(bits[0]), 1'b0, 1'b0);
        end

        single_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        single_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        single_op("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        single_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        drain("directed");

        // Back-to-back random stream.
        n0 = n_out;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1 drive(WIDTH'($urandom()), WIDTH'($urandom()), 1'($urandom()), 1'($urandom()));
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (STAGES + 1) @(negedge clk);
        #1;
        chk("stream_count", longint'(n_out - n0), 100);
        chk("stream_queue_empty", longint'(exp_q.size()), 0);

        // Backpressure mid-stream.
        n0 = n_out;
        s0 = n_stall;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk);
                    #1 drive(WIDTH'($urandom()), WIDTH'($urandom()), 1'($urandom()),
                             1'($urandom()));
                    g = 0;
                    @(negedge clk);
                    while (!bus.in_ready && g < 50) begin
                        @(negedge clk);
                        g++;
                    end
                    chk("bp_accept_timeout", longint'(g < 50), 1);
                end
                @(posedge clk);
                #1 bus.in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain("bp");
        chk("bp_count", longint'(n_out - n0), 10);
        chk("bp_stall_cycles", longint'(n_stall - s0), 5);

        // Reset with three operations in flight, the oldest parked at the output.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 drive(WIDTH'($urandom()), WIDTH'($urandom()), 1'($urandom()), 1'($urandom()));
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        g = 0;
        @(negedge clk);
        while (!bus.out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("rst_fill_timeout", longint'(g < 20), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid_drop", longint'(bus.out_valid), 0);
        chk("rst_sum_clear", longint'(bus.sum), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1 chk("rst_in_ready", longint'(bus.in_ready), 1);
        single_op("post_rst", 16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0);
        drain("post_rst");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; successor to the single-bit combinational full adder.
- WIDTH-bit operands are split into STAGES equal slices. Each slice is added in its own pipeline stage, and the carry is registered between stages.
- Valid/ready handshake with a global stall, so the block can sit in a streaming datapath (accumulators, address generators) and run at high clock rates for wide words.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; slice width SW = WIDTH/STAGES; 1 <= STAGES <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present this cycle.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: A+B+cin; 1: A-B, computed as A+~B+1 with cin ignored.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB; for subtraction, 1 = no borrow (A>=B unsigned).
- ovf  output  1  signed overflow: the carries into and out of the MSB differ.

Behaviour:
- Reset (async assert, sync-released by the system):
  - All valid bits, out_valid, sum, cout, ovf and inter-stage carries clear to 0.
  - in_ready = 1 once rst_n is high.
- Stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational.
  - While stall=1, every pipeline register, including valid bits, holds its value.
- Accept: a transfer occurs when in_valid & in_ready.
- Stage 0:
  - B' = sub ? ~b : b; c0 = sub ? 1 : cin.
  - Adds slice 0 of a and B' with c0. Registers slice-0 sum, carry, the remaining a/B' slices, the sub flag and valid.
  - An empty cycle (no transfer) registers valid=0; other fields are don't-care.
- Stage k (1..STAGES-1):
  - Adds slice k of the delayed operands with the registered carry from stage k-1.
  - Lower completed sum slices shift forward unchanged.
- Output after stage STAGES-1:
  - sum is the concatenation of all slices.
  - cout is the final carry.
  - ovf = carry into the MSB XOR carry out of the MSB, captured in the last stage.
- Latency: a transfer at edge N produces out_valid=1 with its result after edge N+STAGES, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: one operation per cycle when out_ready=1 continuously. Bubbles propagate as valid=0.
- Ordering: results leave in acceptance order; no reordering and no drop.
- Output stability: out_valid, sum, cout and ovf are constant while stall=1.
- out_ready=0 with out_valid=0: no stall; the pipeline keeps advancing and may fill the output register.
- Simultaneous output handshake and new input: both occur in the same cycle.
- STAGES=1: single registered adder, latency 1.
- Reset mid-operation: all in-flight operations are discarded and out_valid drops immediately (asynchronous). No partial result is ever presented.
- Width rules:
  - All adds are SW+1 bits wide; the carry is bit SW.
  - No sign extension; interpretation is left to the consumer via cout/ovf.

Test Plan:
- Exhaustive reuse: run the default config with all eight single-bit (a[0], b[0], cin) combinations and the other bits 0. Each result appears 4 cycles later. Example: a=1, b=1, cin=1 gives sum=0x0003, cout=0.
- Carry ripple across slices: a=0xFFFF, b=0x0000, cin=1, sub=0 -> sum=0x0000, cout=1, ovf=0, exactly 4 cycles after acceptance.
- Subtract and overflow:
  - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
  - a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
- Back-to-back streaming: 100 random (a, b, cin, sub) tuples, in_valid=1 and out_ready=1 every cycle -> 100 results in order, one per cycle after the 4-cycle fill, all matching the reference model.
- Backpressure: stream 10 operations, then hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, outputs frozen, no loss or duplication, and order preserved on release.
- Reset mid-flight: pull rst_n low with 3 operations in flight -> out_valid=0 immediately. After release, a new operation a=0x0010, b=0x0020 appears 4 cycles after acceptance as sum=0x0030, with no stale result in between.
